// File: rtl/stack_ctrl_if.sv
// Request/response, RAM and status signals between the execution unit, the
// operand-stack RAM and stack_ctrl. slave = controller side, master = environment side.
interface stack_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_pops;
  logic              req_push;
  logic [63:0]       push_data;
  logic [1:0]        push_type;
  logic              resp_valid;
  logic [63:0]       resp_a;
  logic [1:0]        resp_a_type;
  logic [63:0]       resp_b;
  logic [1:0]        resp_b_type;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [65:0]       mem_wdata;
  logic [65:0]       mem_rdata;
  logic [ADDR_W:0]   count;
  logic [63:0]       top;
  logic [1:0]        top_type;
  logic              empty;
  logic [2:0]        trap;

  modport slave (
    input  req_valid, req_pops, req_push, push_data, push_type, mem_rdata,
    output req_ready, resp_valid, resp_a, resp_a_type, resp_b, resp_b_type,
           mem_addr, mem_we, mem_wdata, count, top, top_type, empty, trap
  );

  modport master (
    output req_valid, req_pops, req_push, push_data, push_type, mem_rdata,
    input  req_ready, resp_valid, resp_a, resp_a_type, resp_b, resp_b_type,
           mem_addr, mem_we, mem_wdata, count, top, top_type, empty, trap
  );
endinterface

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: pops 0-2 typed values from a single-port RAM, optionally
// pushes one, keeps depth and a cached top-of-stack, and raises a sticky trap.
module stack_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  stack_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, WR, REF, DONE, TRAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [63:0]       top_q, top_d;
  logic [1:0]        top_type_q, top_type_d;
  logic [63:0]       resp_a_q, resp_a_d, resp_b_q, resp_b_d;
  logic [1:0]        resp_a_type_q, resp_a_type_d, resp_b_type_q, resp_b_type_d;
  logic [2:0]        trap_q, trap_d;
  logic [1:0]        pops_q, pops_d;
  logic              push_q, push_d;
  logic [63:0]       push_data_q, push_data_d;
  logic [1:0]        push_type_q, push_type_d;
  logic              ref_q, ref_d;

  logic [2:0]        chk_trap;
  logic [ADDR_W+1:0] after_req;
  logic [ADDR_W:0]   cnt_pop, cnt_m1, cnt_m2;

  assign cnt_pop = count_q - (ADDR_W+1)'(pops_q);
  assign cnt_m1  = count_q - (ADDR_W+1)'(1);
  assign cnt_m2  = count_q - (ADDR_W+1)'(2);

  // Classify an incoming request; the order fixes which trap wins when several apply.
  always_comb begin
    after_req = (ADDR_W+2)'(count_q) - (ADDR_W+2)'(bus.req_pops) + (ADDR_W+2)'(bus.req_push);
    if (bus.req_pops == 2'd3)                              chk_trap = 3'd3;
    else if ((ADDR_W+1)'(bus.req_pops) > count_q)          chk_trap = 3'd1;
    else if (after_req > (ADDR_W+2)'(DEPTH))               chk_trap = 3'd2;
    else                                                   chk_trap = 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        if (chk_trap != 3'd0)       state_d = TRAP;
        else if (bus.req_pops != 0) state_d = RD_A;
        else if (bus.req_push)      state_d = WR;
        else                        state_d = DONE;
      end
      RD_A:    state_d = (pops_q == 2'd2) ? RD_B : CAP;
      RD_B:    state_d = CAP;
      CAP:     state_d = push_q ? WR : ((cnt_pop != '0) ? REF : DONE);
      WR:      state_d = DONE;
      REF:     state_d = DONE;
      DONE:    state_d = IDLE;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.mem_we     = (state_q == WR);
    bus.mem_wdata  = {push_type_q, push_data_q};
    unique case (state_q)
      RD_A:    bus.mem_addr = cnt_m1[ADDR_W-1:0];
      RD_B:    bus.mem_addr = cnt_m2[ADDR_W-1:0];
      WR:      bus.mem_addr = count_q[ADDR_W-1:0];
      REF:     bus.mem_addr = cnt_m1[ADDR_W-1:0];
      default: bus.mem_addr = '0;
    endcase
  end

  // RAM read data lands one cycle after its address, so each capture sits one state later.
  always_comb begin
    count_d       = count_q;
    top_d         = top_q;
    top_type_d    = top_type_q;
    resp_a_d      = resp_a_q;
    resp_a_type_d = resp_a_type_q;
    resp_b_d      = resp_b_q;
    resp_b_type_d = resp_b_type_q;
    trap_d        = trap_q;
    pops_d        = pops_q;
    push_d        = push_q;
    push_data_d   = push_data_q;
    push_type_d   = push_type_q;
    ref_d         = (state_q == REF);
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        if (chk_trap != 3'd0) begin
          trap_d = chk_trap;
        end else begin
          pops_d        = bus.req_pops;
          push_d        = bus.req_push;
          push_data_d   = bus.push_data;
          push_type_d   = bus.push_type;
          resp_a_d      = '0;
          resp_a_type_d = '0;
          resp_b_d      = '0;
          resp_b_type_d = '0;
        end
      end
      RD_B: begin
        resp_a_d      = bus.mem_rdata[63:0];
        resp_a_type_d = bus.mem_rdata[65:64];
      end
      CAP: begin
        if (pops_q == 2'd1) begin
          resp_a_d      = bus.mem_rdata[63:0];
          resp_a_type_d = bus.mem_rdata[65:64];
        end else begin
          resp_b_d      = bus.mem_rdata[63:0];
          resp_b_type_d = bus.mem_rdata[65:64];
        end
        count_d = cnt_pop;
        if (!push_q && cnt_pop == '0) begin
          top_d      = '0;
          top_type_d = '0;
        end
      end
      WR: begin
        count_d    = count_q + (ADDR_W+1)'(1);
        top_d      = push_data_q;
        top_type_d = push_type_q;
      end
      DONE: if (ref_q) begin
        top_d      = bus.mem_rdata[63:0];
        top_type_d = bus.mem_rdata[65:64];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      top_q         <= '0;
      top_type_q    <= '0;
      resp_a_q      <= '0;
      resp_a_type_q <= '0;
      resp_b_q      <= '0;
      resp_b_type_q <= '0;
      trap_q        <= '0;
      pops_q        <= '0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      push_type_q   <= '0;
      ref_q         <= 1'b0;
    end else begin
      count_q       <= count_d;
      top_q         <= top_d;
      top_type_q    <= top_type_d;
      resp_a_q      <= resp_a_d;
      resp_a_type_q <= resp_a_type_d;
      resp_b_q      <= resp_b_d;
      resp_b_type_q <= resp_b_type_d;
      trap_q        <= trap_d;
      pops_q        <= pops_d;
      push_q        <= push_d;
      push_data_q   <= push_data_d;
      push_type_q   <= push_type_d;
      ref_q         <= ref_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.top         = top_q;
  assign bus.top_type    = top_type_q;
  assign bus.resp_a      = resp_a_q;
  assign bus.resp_a_type = resp_a_type_q;
  assign bus.resp_b      = resp_b_q;
  assign bus.resp_b_type = resp_b_type_q;
  assign bus.trap        = trap_q;
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequences the CPU's single-port operand-stack RAM on behalf of the execution unit.
- Each request pops 0–2 typed 64-bit values and then optionally pushes one.
- Maintains the stack depth and a cached top-of-stack, which drive result / result_type / result_empty.
- Raises a sticky trap on underflow, overflow or a malformed request.

Parameters:
- DEPTH, 16, stack entries; power of two, at least 4.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  controller can accept a request
- req_pops  in  2  values to pop (0..2; 3 is illegal)
- req_push  in  1  push one value after the pops
- push_data  in  64  value to push
- push_type  in  2  type tag of push value (cpu.vh encoding)
- resp_valid  out  1  one-cycle completion pulse
- resp_a  out  64  first popped value (old top)
- resp_a_type  out  2  tag of resp_a
- resp_b  out  64  second popped value
- resp_b_type  out  2  tag of resp_b
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  66  {type, data}
- mem_rdata  in  66  RAM read data; valid one cycle after mem_addr
- count  out  ADDR_W+1  current stack depth
- top  out  64  cached top-of-stack value
- top_type  out  2  cached top-of-stack tag
- empty  out  1  count == 0
- trap  out  3  0 none, 1 underflow, 2 overflow, 3 invalid request

Behaviour:
- Reset (async): state IDLE; count, top, top_type, resp_*, trap, mem_we, mem_addr all 0; empty=1; req_ready=1.
- A reset mid-operation abandons the sequence; no RAM write occurs after reset is asserted.
- States: IDLE, RD_A, RD_B, CAP, WR, REF, DONE, TRAP.
- req_ready=1 only in IDLE. req_valid is ignored in every other state.
- Accept in IDLE on req_valid. Latch pops, push, push_data and push_type. Check in this priority order:
  - pops==3 -> trap=3.
  - pops>count -> trap=1.
  - count-pops+push>DEPTH -> trap=2.
  - On any trap: go to TRAP, no RAM access, no resp_valid.
  - Otherwise next state is RD_A if pops>0, WR if push, else DONE.
- RD_A: mem_addr=count-1. Next RD_B if pops==2, else CAP.
- RD_B: capture resp_a from mem_rdata; mem_addr=count-2. Next CAP.
- CAP:
  - Capture resp_a (pops==1) or resp_b (pops==2) from mem_rdata.
  - count -= pops.
  - Next WR if push; else REF if new count>0; else DONE.
- WR:
  - mem_we=1, mem_addr=count (post-pop), mem_wdata={push_type,push_data}.
  - count += 1; top/top_type <= push value.
  - Next DONE.
- REF: mem_addr=new count-1. Next DONE; DONE captures top/top_type from mem_rdata.
- Pop to empty: skip REF; top/top_type become 0.
- DONE: resp_valid=1 for exactly one cycle. Next IDLE.
- resp_a/resp_b hold until the next request overwrites them. Unused resp_b is 0 for the request.
- mem_we is high only in WR.
- TRAP: req_ready=0, trap held, count/top frozen. Only reset exits.
- Latency from accept cycle T to resp_valid:
  - pops0/push0: T+1
  - pops0/push1: T+2
  - pops1/push0: T+4 (T+3 if stack becomes empty)
  - pops1/push1: T+4
  - pops2/push0: T+5 (T+4 if empty)
  - pops2/push1: T+5
- empty = (count==0), combinational from count.
- Full stack with pops1/push1 is legal. Full stack with pops0/push1 -> overflow.

Test Plan:
- Reset, then push 32'hc0000000 with f32 tag (pops0/push1) -> resp_valid at T+2, count=1, top=64'hc0000000, top_type=f32, empty=0.
- Push 5 then 7 (i32), then pops2/push0 -> resp_a=7, resp_b=5, count=0, empty=1, resp_valid at T+4.
- Push 1, 2, 3, then pops2/push1 with data 9 -> resp_a=3, resp_b=2; RAM[1]={i32,9}; count=2; top=9; resp_valid at T+5.
- Empty stack, pops1 -> trap=1, no resp_valid, req_ready=0 stays low; reset clears to trap=0.
- Fill DEPTH=16 entries, then push -> trap=2, count stays 16. Separately, pops=3 -> trap=3.
- Assert reset during RD_B of a pops2 request -> immediate IDLE, count=0, mem_we never high, req_ready=1 after release.
